// File: rtl/cpu_fetch_ctrl_if.sv
// Fetch-side bus bundle: Wishbone read master plus the instruction-FIFO write port.
// master = cpu_fetch_ctrl, slave = memory/FIFO side.
interface cpu_fetch_ctrl_if;
  logic [31:0] wb_adr_o;
  logic        wb_cyc_o;
  logic        wb_stb_o;
  logic [31:0] wb_dat_i;
  logic        wb_ack_i;
  logic        wb_err_i;
  logic        ififo_full_i;
  logic        ififo_we_o;
  logic [31:0] ififo_data_o;
  logic        ififo_newpc_o;
  logic [31:0] ififo_pc_o;

  modport master (
    output wb_adr_o, wb_cyc_o, wb_stb_o,
    input  wb_dat_i, wb_ack_i, wb_err_i,
    input  ififo_full_i,
    output ififo_we_o, ififo_data_o, ififo_newpc_o, ififo_pc_o
  );

  modport slave (
    input  wb_adr_o, wb_cyc_o, wb_stb_o,
    output wb_dat_i, wb_ack_i, wb_err_i,
    output ififo_full_i,
    input  ififo_we_o, ififo_data_o, ififo_newpc_o, ififo_pc_o
  );
endinterface

// File: rtl/cpu_fetch_ctrl.sv
// mox125 instruction-fetch sequencer: one outstanding Wishbone read, pushes words to cpu_ififo.
// Define CPU_FETCH_ABORT_EN to abort an in-flight read on redirect instead of draining it.
module cpu_fetch_ctrl #(
  parameter logic [31:0] BOOT_ADDRESS = 32'h00001000
) (
  input  logic                   clk_i,
  input  logic                   rst_i,
  input  logic                   branch_flush_i,
  input  logic [31:0]            branch_pc_i,
  output logic                   fetch_fault_o,
  cpu_fetch_ctrl_if.master       bus
);

  typedef enum logic [2:0] {
    ST_BOOT,
    ST_IDLE,
    ST_REQ,
    ST_PUSH,
    ST_DRAIN,
    ST_FAULT
  } state_e;

  state_e      state_q, state_d;
  logic [31:0] fa_q, fa_d;
  logic [31:0] adr_q, adr_d;
  logic [31:0] data_q, data_d;
  logic [31:0] pc_q, pc_d;
  logic        bus_q, bus_d;

  logic flush;
  logic resp;

  // Redirects are ignored during the boot pulse so the two new-PC events never collide.
  assign flush = branch_flush_i && (state_q != ST_BOOT);
  assign resp  = bus.wb_ack_i || bus.wb_err_i;

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      state_q <= ST_BOOT;
      fa_q    <= BOOT_ADDRESS;
      adr_q   <= 32'd0;
      data_q  <= 32'd0;
      pc_q    <= BOOT_ADDRESS;
      bus_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      fa_q    <= fa_d;
      adr_q   <= adr_d;
      data_q  <= data_d;
      pc_q    <= pc_d;
      bus_q   <= bus_d;
    end
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      ST_BOOT:  state_d = ST_IDLE;
      ST_IDLE: begin
        if (!flush && !bus.ififo_full_i) state_d = ST_REQ;
      end
      ST_REQ: begin
        if (flush) begin
`ifdef CPU_FETCH_ABORT_EN
          state_d = ST_IDLE;
`else
          state_d = resp ? ST_IDLE : ST_DRAIN;
`endif
        end else if (bus.wb_ack_i) begin
          state_d = ST_PUSH;
        end else if (bus.wb_err_i) begin
          state_d = ST_FAULT;
        end
      end
      ST_PUSH:  state_d = ST_IDLE;
      ST_DRAIN: begin
        if (resp) state_d = ST_IDLE;
      end
      ST_FAULT: begin
        if (flush) state_d = ST_IDLE;
      end
      default:  state_d = ST_IDLE;
    endcase
  end

  always_comb begin
    fa_d   = fa_q;
    adr_d  = adr_q;
    data_d = data_q;
    pc_d   = pc_q;
    if (flush) begin
      fa_d = {branch_pc_i[31:1], 1'b0};
      pc_d = branch_pc_i;
    end else if (state_q == ST_REQ && bus.wb_ack_i) begin
      fa_d   = fa_q + 32'd4;
      data_d = bus.wb_dat_i;
    end
    // The bus address is frozen at request start so a drain keeps the old address.
    if (state_q == ST_IDLE && state_d == ST_REQ) adr_d = fa_q;
    bus_d = (state_d == ST_REQ) || (state_d == ST_DRAIN);
  end

  always_comb begin
`ifdef CPU_FETCH_ABORT_EN
    bus.wb_cyc_o = bus_q && !(state_q == ST_REQ && flush);
    bus.wb_stb_o = bus_q && !(state_q == ST_REQ && flush);
`else
    bus.wb_cyc_o = bus_q;
    bus.wb_stb_o = bus_q;
`endif
    bus.wb_adr_o      = adr_q;
    bus.ififo_we_o    = (state_q == ST_PUSH) && !flush;
    bus.ififo_data_o  = data_q;
    // rst_i gate keeps the boot pulse quiet while reset is still held.
    bus.ififo_newpc_o = flush || (state_q == ST_BOOT && rst_i);
    bus.ififo_pc_o    = flush ? branch_pc_i : pc_q;
    fetch_fault_o     = (state_q == ST_FAULT);
  end

endmodule

// File: tb/tb_cpu_fetch_ctrl.sv
// Directed test-plan sequence followed by a randomized run checked against a transaction-level fetch model.
module tb_cpu_fetch_ctrl;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        flush;
  logic [31:0] bpc;
  logic        fault;
  int          tests = 0;
  int          fails = 0;

  cpu_fetch_ctrl_if bus_if ();

  cpu_fetch_ctrl #(.BOOT_ADDRESS(32'h00001000)) dut (
    .clk_i          (clk),
    .rst_i          (rst_n),
    .branch_flush_i (flush),
    .branch_pc_i    (bpc),
    .fetch_fault_o  (fault),
    .bus            (bus_if)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return {a[15:0], a[31:16]} ^ 32'h5A5AC3C3;
  endfunction

  // Random-phase model state: next expected fetch address, live request, pending FIFO write.
  logic [31:0] exp_addr;
  logic        live;
  logic        pending;
  logic [31:0] pending_data;
  logic        stb_prev;
  logic        stb_s;
  logic [31:0] adr_s;
  int          wait_cnt;

  initial begin
    bus_if.wb_dat_i     = 32'd0;
    bus_if.wb_ack_i     = 1'b0;
    bus_if.wb_err_i     = 1'b0;
    bus_if.ififo_full_i = 1'b0;
    flush = 1'b0;
    bpc   = 32'd0;
    rst_n = 1'b1;
    #1 rst_n = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_cyc",   bus_if.wb_cyc_o, 0);
    chk("rst_stb",   bus_if.wb_stb_o, 0);
    chk("rst_adr",   bus_if.wb_adr_o, 0);
    chk("rst_we",    bus_if.ififo_we_o, 0);
    chk("rst_data",  bus_if.ififo_data_o, 0);
    chk("rst_newpc", bus_if.ififo_newpc_o, 0);
    chk("rst_pc",    bus_if.ififo_pc_o, 32'h00001000);
    chk("rst_fault", fault, 0);

    // Boot: newPC pulse then two zero-wait fetches
    rst_n = 1'b1;
    #1;
    chk("boot_newpc", bus_if.ififo_newpc_o, 1);
    chk("boot_pc",    bus_if.ififo_pc_o, 32'h00001000);
    chk("boot_stb",   bus_if.wb_stb_o, 0);
    tick(); #1;
    chk("idle_stb",   bus_if.wb_stb_o, 0);
    chk("idle_newpc", bus_if.ififo_newpc_o, 0);
    tick();
    chk("req1_stb", bus_if.wb_stb_o, 1);
    chk("req1_cyc", bus_if.wb_cyc_o, 1);
    chk("req1_adr", bus_if.wb_adr_o, 32'h00001000);
    bus_if.wb_ack_i = 1'b1; bus_if.wb_dat_i = 32'h01230456;
    tick(); bus_if.wb_ack_i = 1'b0; #1;
    chk("push1_we",   bus_if.ififo_we_o, 1);
    chk("push1_data", bus_if.ififo_data_o, 32'h01230456);
    chk("push1_stb",  bus_if.wb_stb_o, 0);
    tick(); #1;
    chk("push1_once", bus_if.ififo_we_o, 0);
    tick();
    chk("req2_adr", bus_if.wb_adr_o, 32'h00001004);
    chk("req2_stb", bus_if.wb_stb_o, 1);
    bus_if.wb_ack_i = 1'b1; bus_if.wb_dat_i = 32'h789A0000;
    tick(); bus_if.wb_ack_i = 1'b0; bus_if.ififo_full_i = 1'b1; #1;
    chk("push2_we",   bus_if.ififo_we_o, 1);
    chk("push2_data", bus_if.ififo_data_o, 32'h789A0000);
    tick();

    // Back-pressure: no strobe while full
    for (int i = 0; i < 10; i++) begin
      chk("bp_stb", bus_if.wb_stb_o, 0);
      tick();
    end
    bus_if.ififo_full_i = 1'b0; #1;
    chk("bp_release_stb", bus_if.wb_stb_o, 0);
    tick();
    chk("bp_first_stb", bus_if.wb_stb_o, 1);
    chk("bp_first_adr", bus_if.wb_adr_o, 32'h00001008);

    // Redirect during a wait-stated read at 0x1008 (ack 4 cycles after the flush)
    flush = 1'b1; bpc = 32'h00004000; #1;
    chk("ws_newpc", bus_if.ififo_newpc_o, 1);
    chk("ws_pc",    bus_if.ififo_pc_o, 32'h00004000);
    chk("ws_we",    bus_if.ififo_we_o, 0);
`ifdef CPU_FETCH_ABORT_EN
    chk("ws_abort_cyc_now", bus_if.wb_cyc_o, 0);
    tick(); flush = 1'b0; #1;
    chk("ws_abort_cyc", bus_if.wb_cyc_o, 0);
    tick();
`else
    tick(); flush = 1'b0;
    for (int i = 1; i < 4; i++) begin
      #1;
      chk("drain_stb", bus_if.wb_stb_o, 1);
      chk("drain_adr", bus_if.wb_adr_o, 32'h00001008);
      chk("drain_we",  bus_if.ififo_we_o, 0);
      tick();
    end
    bus_if.wb_ack_i = 1'b1; bus_if.wb_dat_i = 32'hDEADBEEF; #1;
    chk("drain_ack_stb", bus_if.wb_stb_o, 1);
    chk("drain_ack_adr", bus_if.wb_adr_o, 32'h00001008);
    tick(); bus_if.wb_ack_i = 1'b0; #1;
    chk("drain_done_stb", bus_if.wb_stb_o, 0);
    chk("drain_done_we",  bus_if.ififo_we_o, 0);
    tick();
`endif
    chk("ws_target_stb", bus_if.wb_stb_o, 1);
    chk("ws_target_adr", bus_if.wb_adr_o, 32'h00004000);

    // Flush coincident with ack: data must be dropped
    bus_if.wb_ack_i = 1'b1; bus_if.wb_dat_i = 32'hBAD0BAD0;
    flush = 1'b1; bpc = 32'h00005000; #1;
    chk("co_newpc", bus_if.ififo_newpc_o, 1);
    chk("co_pc",    bus_if.ififo_pc_o, 32'h00005000);
    tick(); bus_if.wb_ack_i = 1'b0; flush = 1'b0; #1;
    chk("co_we",  bus_if.ififo_we_o, 0);
    chk("co_stb", bus_if.wb_stb_o, 0);
    tick();
    chk("co_target_adr", bus_if.wb_adr_o, 32'h00005000);
    chk("co_target_stb", bus_if.wb_stb_o, 1);
    chk("co_we_later",   bus_if.ififo_we_o, 0);
    bus_if.wb_ack_i = 1'b1; bus_if.wb_dat_i = 32'h11112222;
    tick(); bus_if.wb_ack_i = 1'b0; #1;
    chk("co_push_we",   bus_if.ififo_we_o, 1);
    chk("co_push_data", bus_if.ififo_data_o, 32'h11112222);
    tick();

    // Redirect in IDLE to a halfword-aligned target
    flush = 1'b1; bpc = 32'h00002002; #1;
    chk("idle_fl_newpc", bus_if.ififo_newpc_o, 1);
    chk("idle_fl_pc",    bus_if.ififo_pc_o, 32'h00002002);
    chk("idle_fl_we",    bus_if.ififo_we_o, 0);
    tick(); flush = 1'b0; #1;
    chk("idle_fl_stb", bus_if.wb_stb_o, 0);
    tick();
    chk("idle_fl_adr0", bus_if.wb_adr_o, 32'h00002002);
    bus_if.wb_ack_i = 1'b1; bus_if.wb_dat_i = 32'h0000AAAA;
    tick(); bus_if.wb_ack_i = 1'b0;
    tick(); tick();
    chk("idle_fl_adr1", bus_if.wb_adr_o, 32'h00002006);
    bus_if.wb_ack_i = 1'b1;
    tick(); bus_if.wb_ack_i = 1'b0;
    tick();

    // Bus error at 0x3000
    flush = 1'b1; bpc = 32'h00003000;
    tick(); flush = 1'b0;
    tick();
    chk("err_adr", bus_if.wb_adr_o, 32'h00003000);
    bus_if.wb_err_i = 1'b1;
    tick(); bus_if.wb_err_i = 1'b0;
    for (int i = 0; i < 20; i++) begin
      #1;
      chk("fault_flag", fault, 1);
      chk("fault_cyc",  bus_if.wb_cyc_o, 0);
      tick();
    end
    flush = 1'b1; bpc = 32'hFFFFFFFC; #1;
    chk("fault_fl_newpc", bus_if.ififo_newpc_o, 1);
    tick(); flush = 1'b0; #1;
    chk("fault_clear", fault, 0);
    tick();
    chk("wrap_adr0", bus_if.wb_adr_o, 32'hFFFFFFFC);
    bus_if.wb_ack_i = 1'b1; bus_if.wb_dat_i = 32'h13572468;
    tick(); bus_if.wb_ack_i = 1'b0; #1;
    chk("wrap_push", bus_if.ififo_data_o, 32'h13572468);
    tick(); tick();
    chk("wrap_adr1", bus_if.wb_adr_o, 32'h00000000);
    chk("wrap_stb",  bus_if.wb_stb_o, 1);

    // Reset in the middle of a bus cycle
    rst_n = 1'b0; #1;
    chk("mrst_cyc",   bus_if.wb_cyc_o, 0);
    chk("mrst_stb",   bus_if.wb_stb_o, 0);
    chk("mrst_pc",    bus_if.ififo_pc_o, 32'h00001000);
    chk("mrst_newpc", bus_if.ififo_newpc_o, 0);
    chk("mrst_we",    bus_if.ififo_we_o, 0);
    tick(); rst_n = 1'b1; #1;
    chk("mrst_boot_newpc", bus_if.ififo_newpc_o, 1);
    tick();

    // Randomized run against the fetch-stream model
    exp_addr = 32'h00001000;
    live = 1'b0; pending = 1'b0; pending_data = 32'd0;
    stb_prev = 1'b0; wait_cnt = 0;
    for (int cyc = 0; cyc < 600; cyc++) begin
      stb_s = bus_if.wb_stb_o;
      adr_s = bus_if.wb_adr_o;
      if (stb_s && !stb_prev) begin
        chk("rnd_req_adr", adr_s, exp_addr);
        live = 1'b1;
        wait_cnt = $urandom_range(0, 3);
      end
      bus_if.wb_ack_i = stb_s && (wait_cnt == 0);
      if (stb_s && wait_cnt > 0) wait_cnt--;
      bus_if.wb_dat_i = bus_if.wb_ack_i ? mem_word(adr_s) : $urandom;
      flush = ($urandom_range(0, 11) == 0);
      bpc = $urandom & 32'hFFFFFFFE;
      bus_if.ififo_full_i = ($urandom_range(0, 3) == 0);
      #1;
      chk("rnd_newpc", bus_if.ififo_newpc_o, flush);
      if (flush) chk("rnd_pc", bus_if.ififo_pc_o, bpc);
      chk("rnd_we", bus_if.ififo_we_o, pending && !flush);
      if (pending && !flush) chk("rnd_data", bus_if.ififo_data_o, pending_data);
      chk("rnd_fault", fault, 0);
      pending = 1'b0;
      if (flush) begin
        exp_addr = bpc;
        live = 1'b0;
      end else if (bus_if.wb_ack_i && live) begin
        pending = 1'b1;
        pending_data = mem_word(adr_s);
        exp_addr = exp_addr + 32'd4;
        live = 1'b0;
      end else if (bus_if.wb_ack_i) begin
        live = 1'b0;
      end
      stb_prev = stb_s;
      tick();
    end
    bus_if.wb_ack_i = 1'b0;
    flush = 1'b0;

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/cpu_fetch_ctrl.md
# cpu_fetch_ctrl

Instruction-fetch sequencer for the mox125 front end. It issues 32-bit Wishbone reads from a running fetch address, pushes each returned word into the instruction FIFO (`cpu_ififo`) whenever the FIFO has room, and restarts fetching on branch redirects. It also generates the FIFO's new-PC pulse, so the FIFO and the fetch stream always restart from the same address.

## Interface
- `BOOT_ADDRESS`, default 32'h00001000: first fetch address after reset.
- `clk_i`  in  1  clock; all state changes on the rising edge.
- `rst_i`  in  1  asynchronous, active-low reset.
- `branch_flush_i`  in  1  single-cycle redirect request.
- `branch_pc_i`  in  32  redirect target; must be halfword aligned.
- `ififo_full_i`  in  1  FIFO `full_o` (FIFO holds 3 or 4 halfwords).
- `ififo_we_o`  out  1  FIFO `write_en_i`.
- `ififo_data_o`  out  32  FIFO `data_i`.
- `ififo_newpc_o`  out  1  FIFO `newPC_p_i`.
- `ififo_pc_o`  out  32  FIFO `PC_i`.
- `wb_adr_o`  out  32  fetch address.
- `wb_cyc_o`, `wb_stb_o`  out  1  bus cycle and strobe.
- `wb_dat_i`  in  32  read data.
- `wb_ack_i`, `wb_err_i`  in  1  bus response.
- `fetch_fault_o`  out  1  a bus error stopped fetching.

## Operation
- States:
  - `BOOT` (reset state).
  - `IDLE`.
  - `REQ`.
  - `PUSH`.
  - `DRAIN`.
  - `FAULT`.
- **Reset values:**
  - All outputs 0, except `ififo_pc_o` = `BOOT_ADDRESS`.
  - Internal fetch address `fa` = `BOOT_ADDRESS`.
- **`BOOT`:** one cycle with `ififo_newpc_o`=1 and `ififo_pc_o`=`BOOT_ADDRESS`, then go to `IDLE`.
- **`IDLE`:**
  - If `ififo_full_i`=0, go to `REQ`.
  - Otherwise stay in `IDLE`.
- **`REQ`:**
  - Drive `wb_cyc_o`=`wb_stb_o`=1 and `wb_adr_o`=`fa`.
  - On `wb_ack_i`: capture `wb_dat_i` into `ififo_data_o`, set `fa` ← `fa`+4, go to `PUSH`.
  - On `wb_err_i`: go to `FAULT`.
- **`PUSH`:** `ififo_we_o`=1 for exactly one cycle, then go to `IDLE`.
  - The extra `IDLE` cycle lets the FIFO's `full_o` reflect the write before the next request.
  - Only one request is outstanding at a time. Starting from `full_i`=0 (≤2 halfwords held), one 32-bit write always fits.
- **Address arithmetic:**
  - `fa` is 32-bit and wraps modulo 2^32 (32'hFFFFFFFC + 4 = 0).
  - `fa[0]` is always 0. `fa[1]` is passed through; the memory side handles halfword-aligned word reads.
- **Redirect (`branch_flush_i`=1), any state except `BOOT`:**
  - Same cycle, combinationally: `ififo_newpc_o`=1, `ififo_pc_o`=`branch_pc_i`, `ififo_we_o` forced to 0.
  - Next cycle: `fa` = `{branch_pc_i[31:1],1'b0}`.
  - From `IDLE`, `PUSH` or `FAULT`: go to `IDLE`. `fetch_fault_o` clears and pending push data is discarded.
  - From `REQ` without ack/err that cycle: go to `DRAIN`.
  - From `REQ` with ack or err that cycle: the response is discarded and the next state is `IDLE`.
- **`DRAIN`:**
  - Keep `wb_cyc_o`/`wb_stb_o` asserted with the old address until ack or err.
  - Discard the response and go to `IDLE`. A bus error during drain does not fault.
  - A second flush during `DRAIN` re-latches `fa` and stays in `DRAIN`.
- **`FAULT`:** bus idle and `fetch_fault_o`=1 until `branch_flush_i`.
- **Reset mid-cycle:** all outputs return to reset values immediately, including dropping `wb_cyc_o` with no ack.

## Timing
- Reset release to first `wb_stb_o`: 2 cycles (`BOOT`, `IDLE`), assuming `ififo_full_i`=0.
- Ack to `ififo_we_o`: 1 cycle, registered.
- Steady-state throughput with zero-wait-state ack: one word per 3 cycles (`REQ`, `PUSH`, `IDLE`).
- Redirect to first new `wb_stb_o`:
  - 1 cycle from `IDLE`/`PUSH`.
  - Drain latency plus 1 cycle from `REQ`.
- All bus and FIFO-data outputs are registered. Only the `ififo_newpc_o`/`ififo_pc_o`/`ififo_we_o` flush gating is combinational.

## Configuration
- **`CPU_FETCH_ABORT_EN` defined:**
  - A flush in `REQ` drops `wb_cyc_o`/`wb_stb_o` in the same cycle (Wishbone abort) and goes to `IDLE`.
  - `DRAIN` is never entered.
  - Redirect to new `wb_stb_o` is 1 cycle.
- **`CPU_FETCH_ABORT_EN` undefined:** drain behaviour as described under Operation.

## Test plan
- **Boot:** release reset, ack every strobe immediately with `wb_dat_i` = 32'h01230456 (first word) and 32'h789A0000 (second word). Required:
  - `ififo_newpc_o` pulse with PC 32'h00001000.
  - `wb_adr_o` sequence 32'h1000, 32'h1004.
  - `ififo_we_o` asserted one cycle after each ack, with matching data.
- **Back-pressure:** hold `ififo_full_i`=1 for 10 cycles. Required: no `wb_stb_o`; the first strobe follows 1 cycle after `ififo_full_i` falls.
- **Redirect in `IDLE`:** flush to 32'h00002002. Required:
  - Same-cycle `ififo_newpc_o`=1 with `ififo_pc_o`=32'h2002.
  - Next `wb_adr_o`=32'h2002, then 32'h2006.
- **Redirect during a wait-stated read:** at 32'h1008, with ack 4 cycles later. Required:
  - Abort off: strobe held at 32'h1008 until ack, no `ififo_we_o`, then a request to the target.
  - Abort on: `wb_cyc_o` low the next cycle.
- **Flush coincident with ack:** required: that data is never written to the FIFO, and the next address is the branch target.
- **Bus error:** `wb_err_i` at 32'h3000. Required:
  - `fetch_fault_o`=1 and the bus is idle for 20 cycles.
  - A flush clears the fault and resumes at the target.
  - Wrap check: fetch from 32'hFFFFFFFC; next address is 32'h00000000.
